jts18_vdp_mix: RTL and testbench



---
 rtl/jts18_mix_pkg.sv | 20 ++
 rtl/jts18_mix_dly.sv | 36 +++
 rtl/jts18_vdp_mix.sv | 105 ++++++++++
 tb/tb_jts18_vdp_mix.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jts18_mix_pkg.sv
// Shared definitions for the System 18 pixel mixer: colour field widths,
// VDP colour expansion and the st_show view selectors.
// Pure declarations, no state; no flow control involved.
package jts18_mix_pkg;

  localparam int S16_CW = 5;  // bits per channel on the System 16 palette side
  localparam int VDP_CW = 3;  // bits per channel on the VDP side

  // st_show view selectors, decoded from debug_bus[1:0]
  localparam logic [1:0] ST_CNT_LO = 2'd0;
  localparam logic [1:0] ST_CNT_HI = 2'd1;
  localparam logic [1:0] ST_PIX    = 2'd2;
  localparam logic [1:0] ST_RED    = 2'd3;

  // Replicating the top bits keeps full-scale white at full scale (7 -> 31).
  function automatic logic [S16_CW-1:0] vdp_expand(input logic [VDP_CW-1:0] c);
    return {c, c[VDP_CW-1 -: 2]};
  endfunction

endpackage

// File: rtl/jts18_mix_dly.sv
// Generic pxl_cen-gated delay line; N=0 is a plain wire.
// Latency: N pxl_cen ticks. No backpressure: advances on every pxl_cen.
// Ports: clk, rst_n, cen (advance), din[W] in, dout[W] = din from N ticks ago.
module jts18_mix_dly #(
  parameter int W = 1,
  parameter int N = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (N == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst_n, cen};
      assign dout = din;
    end else begin : g_sr
      logic [W-1:0] sr [N];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < N; i++) sr[i] <= '0;
        end else if (cen) begin
          sr[0] <= din;
          for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
        end
      end

      assign dout = sr[N-1];
    end
  endgenerate

endmodule

// File: rtl/jts18_vdp_mix.sv
// System 18 final pixel mixer: aligns S16/VDP/selection streams, picks per pixel, blanks, counts VDP pixels per frame.
// Latency: max(S16_DLY,VDP_DLY,SEL_DLY)+1 pxl_cen ticks for blanking; each colour stream sees its own delay +1.
// No backpressure: one pixel per pxl_cen, outputs hold between ticks.
// Ports: clk/rst_n/pxl_cen; LHBL/LVBL blanking; vdp_en/vdp_sel selection; s16_rgb, vdp_rgb colours;
//        debug_bus view select; red/green/blue, LHBL_dly/LVBL_dly aligned video; sel_cnt last-frame count; st_show.
module jts18_vdp_mix
  import jts18_mix_pkg::*;
#(
  parameter int S16_DLY = 2,
  parameter int VDP_DLY = 0,
  parameter int SEL_DLY = 1,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pxl_cen,
  input  logic            LHBL,
  input  logic            LVBL,
  input  logic            vdp_en,
  input  logic            vdp_sel,
  input  logic [14:0]     s16_rgb,
  input  logic [8:0]      vdp_rgb,
  input  logic [7:0]      debug_bus,
  output logic [4:0]      red,
  output logic [4:0]      green,
  output logic [4:0]      blue,
  output logic            LHBL_dly,
  output logic            LVBL_dly,
  output logic [CNTW-1:0] sel_cnt,
  output logic [7:0]      st_show
);

  localparam int MAXD_SV = (S16_DLY > VDP_DLY) ? S16_DLY : VDP_DLY;
  localparam int MAXD    = (MAXD_SV > SEL_DLY) ? MAXD_SV : SEL_DLY;

  generate
    if (S16_DLY < 0 || S16_DLY > 7 || VDP_DLY < 0 || VDP_DLY > 7 || SEL_DLY < 0 || SEL_DLY > 7) begin : g_bad_dly
      $error("jts18_vdp_mix: S16_DLY, VDP_DLY and SEL_DLY must be in 0-7");
    end
  endgenerate

  logic [14:0] s16_d;
  logic [8:0]  vdp_d;
  logic        en_d, sel_d, hb_d, vb_d;

  jts18_mix_dly #(.W(15), .N(S16_DLY)) u_s16 (
    .clk(clk), .rst_n(rst_n), .cen(pxl_cen), .din(s16_rgb), .dout(s16_d));
  jts18_mix_dly #(.W(9), .N(VDP_DLY)) u_vdp (
    .clk(clk), .rst_n(rst_n), .cen(pxl_cen), .din(vdp_rgb), .dout(vdp_d));
  // vdp_en rides with vdp_sel so an enable change lands on a pixel boundary
  jts18_mix_dly #(.W(2), .N(SEL_DLY)) u_sel (
    .clk(clk), .rst_n(rst_n), .cen(pxl_cen), .din({vdp_en, vdp_sel}), .dout({en_d, sel_d}));
  jts18_mix_dly #(.W(2), .N(MAXD)) u_blk (
    .clk(clk), .rst_n(rst_n), .cen(pxl_cen), .din({LHBL, LVBL}), .dout({hb_d, vb_d}));

  logic            pick, act, inc, fall, lvbl_q;
  logic [14:0]     mix;
  logic [CNTW-1:0] acc, acc_nxt, cnt_nxt;
  logic [15:0]     cnt16;
  logic [7:0]      st_nxt;
  logic [5:0]      unused_dbg;

  assign unused_dbg = debug_bus[7:2];

  always_comb begin
    pick = en_d & sel_d;
    act  = hb_d & vb_d;
    inc  = pick & act;
    mix  = '0;
    if (act) mix = pick ? {vdp_expand(vdp_d[8:6]), vdp_expand(vdp_d[5:3]), vdp_expand(vdp_d[2:0])}
                        : s16_d;
    acc_nxt = (inc && !(&acc)) ? acc + CNTW'(1) : acc;
    // frame end seen one tick after LVBL_dly drops; that tick's count still belongs to the old frame
    fall    = lvbl_q & ~LVBL_dly;
    cnt_nxt = fall ? acc_nxt : sel_cnt;
    cnt16   = 16'(cnt_nxt);
    case (debug_bus[1:0])
      ST_CNT_LO: st_nxt = cnt16[7:0];
      ST_CNT_HI: st_nxt = cnt16[15:8];
      ST_PIX:    st_nxt = {5'd0, vdp_en, vdp_sel, pick};
      default:   st_nxt = {3'd0, mix[14:10]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {red, green, blue} <= '0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
      lvbl_q   <= 1'b0;
      acc      <= '0;
      sel_cnt  <= '0;
      st_show  <= '0;
    end else if (pxl_cen) begin
      {red, green, blue} <= mix;
      LHBL_dly <= hb_d;
      LVBL_dly <= vb_d;
      lvbl_q   <= LVBL_dly;
      acc      <= fall ? '0 : acc_nxt;
      sel_cnt  <= cnt_nxt;
      st_show  <= st_nxt;
    end
  end

endmodule

// File: tb/tb_jts18_vdp_mix.sv
module tb_jts18_vdp_mix;
  localparam int S16D = 2;
  localparam int VDPD = 0;
  localparam int SELD = 1;
  localparam int MAXD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pxl_cen = 1'b0;
  logic        LHBL = 1'b0, LVBL = 1'b0, vdp_en = 1'b0, vdp_sel = 1'b0;
  logic [14:0] s16_rgb = '0;
  logic [8:0]  vdp_rgb = '0;
  logic [7:0]  debug_bus = '0;

  logic [4:0]  a_red, a_green, a_blue, b_red, b_green, b_blue;
  logic        a_hb, a_vb, b_hb, b_vb;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;
  logic [7:0]  a_st, b_st;

  always #5 clk = ~clk;

  jts18_vdp_mix u_a (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .vdp_en(vdp_en), .vdp_sel(vdp_sel), .s16_rgb(s16_rgb), .vdp_rgb(vdp_rgb),
    .debug_bus(debug_bus), .red(a_red), .green(a_green), .blue(a_blue),
    .LHBL_dly(a_hb), .LVBL_dly(a_vb), .sel_cnt(a_cnt), .st_show(a_st));

  jts18_vdp_mix #(.CNTW(4)) u_b (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .vdp_en(vdp_en), .vdp_sel(vdp_sel), .s16_rgb(s16_rgb), .vdp_rgb(vdp_rgb),
    .debug_bus(debug_bus), .red(b_red), .green(b_green), .blue(b_blue),
    .LHBL_dly(b_hb), .LVBL_dly(b_vb), .sel_cnt(b_cnt), .st_show(b_st));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [14:0] h_s16 [8];
  logic [8:0]  h_vdp [8];
  logic [1:0]  h_se  [8];
  logic [1:0]  h_bl  [8];
  logic [14:0] m_rgb;
  logic        m_hb, m_vb, m_vbq;
  logic [15:0] m_acc, m_cnt;
  logic [3:0]  mb_acc, mb_cnt;
  logic [7:0]  m_st, mb_st;
  logic [63:0] sb_a[$];
  logic [63:0] sb_b[$];

  function automatic logic [4:0] x35(input logic [2:0] c);
    return {c, c[2:1]};
  endfunction

  function automatic logic [63:0] got_a();
    return {23'd0, a_red, a_green, a_blue, a_hb, a_vb, a_cnt, a_st};
  endfunction
  function automatic logic [63:0] got_b();
    return {35'd0, b_red, b_green, b_blue, b_hb, b_vb, b_cnt, b_st};
  endfunction
  function automatic logic [63:0] exp_a();
    return {23'd0, m_rgb, m_hb, m_vb, m_cnt, m_st};
  endfunction
  function automatic logic [63:0] exp_b();
    return {35'd0, m_rgb, m_hb, m_vb, mb_cnt, mb_st};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      h_s16[i] = '0; h_vdp[i] = '0; h_se[i] = '0; h_bl[i] = '0;
    end
    m_rgb = '0; m_hb = 0; m_vb = 0; m_vbq = 0;
    m_acc = '0; m_cnt = '0; mb_acc = '0; mb_cnt = '0; m_st = '0; mb_st = '0;
  endtask

  task automatic model_tick();
    logic [14:0] s;
    logic [8:0]  v;
    logic        pick, act, inc, fall;
    for (int i = 7; i > 0; i--) begin
      h_s16[i] = h_s16[i-1]; h_vdp[i] = h_vdp[i-1]; h_se[i] = h_se[i-1]; h_bl[i] = h_bl[i-1];
    end
    h_s16[0] = s16_rgb; h_vdp[0] = vdp_rgb; h_se[0] = {vdp_en, vdp_sel}; h_bl[0] = {LHBL, LVBL};
    s    = h_s16[S16D];
    v    = h_vdp[VDPD];
    pick = h_se[SELD][1] & h_se[SELD][0];
    act  = h_bl[MAXD][1] & h_bl[MAXD][0];
    inc  = pick & act;
    fall = m_vbq & ~m_vb;
    if (fall) begin
      m_cnt  = (inc && m_acc != 16'hFFFF) ? m_acc + 16'd1 : m_acc;
      mb_cnt = (inc && mb_acc != 4'hF) ? mb_acc + 4'd1 : mb_acc;
      m_acc  = '0;
      mb_acc = '0;
    end else begin
      if (inc && m_acc != 16'hFFFF) m_acc = m_acc + 16'd1;
      if (inc && mb_acc != 4'hF) mb_acc = mb_acc + 4'd1;
    end
    m_vbq = m_vb;
    m_hb  = h_bl[MAXD][1];
    m_vb  = h_bl[MAXD][0];
    if (!act) m_rgb = '0;
    else if (pick) m_rgb = {x35(v[8:6]), x35(v[5:3]), x35(v[2:0])};
    else m_rgb = s;
    case (debug_bus[1:0])
      2'd0: begin m_st = m_cnt[7:0];  mb_st = {4'd0, mb_cnt}; end
      2'd1: begin m_st = m_cnt[15:8]; mb_st = 8'd0; end
      2'd2: begin m_st = {5'd0, vdp_en, vdp_sel, pick}; mb_st = m_st; end
      default: begin m_st = {3'd0, m_rgb[14:10]}; mb_st = m_st; end
    endcase
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
    if (sb_a.size() == 0 || sb_b.size() == 0) begin
      check("sb_empty", 64'(sb_a.size() + sb_b.size()), 64'd2);
    end else begin
      check("pix_a", got_a(), sb_a.pop_front());
      check("pix_b", got_b(), sb_b.pop_front());
    end
  endtask

  task automatic px(input logic hb, input logic vb, input logic en, input logic sel,
                    input logic [14:0] s, input logic [8:0] v);
    LHBL = hb; LVBL = vb; vdp_en = en; vdp_sel = sel; s16_rgb = s; vdp_rgb = v;
    pxl_cen = 1'b1;
    model_tick();
    sb_a.push_back(exp_a());
    sb_b.push_back(exp_b());
    settle();
  endtask

  // inputs wiggle with pxl_cen low: nothing may move
  task automatic hold_px();
    pxl_cen = 1'b0;
    s16_rgb = 15'($urandom); vdp_rgb = 9'($urandom);
    vdp_sel = ~vdp_sel; LHBL = ~LHBL; LVBL = ~LVBL;
    sb_a.push_back(exp_a());
    sb_b.push_back(exp_b());
    settle();
  endtask

  task automatic frame(input int lines, input int width, input int nsel);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < width; x++)
        px(1, 1, 1, (x >= 10 && x < 260 && (y * 250 + x - 10) < nsel), 15'($urandom), 9'($urandom));
      px(0, 1, 0, 0, '0, '0);
      px(0, 1, 0, 0, '0, '0);
    end
    repeat (8) px(0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, nz, pos;
    model_clear();
    #2 rst_n = 1'b0;
    #1;
    check("rst_init_a", got_a(), 64'd0);
    check("rst_init_b", got_b(), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // first active pixel latency
    debug_bus = 8'd3;
    repeat (4) px(0, 1, 0, 0, 15'h7FFF, '0);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      px(1, 1, 0, 0, 15'h7FFF, '0);
      if (a_hb) lat = i;
    end
    check("latency", lat, MAXD + 1);
    check("first_rgb", {a_red, a_green, a_blue}, 15'h7FFF);

    // single selected VDP pixel inside an S16 white line, then inside black
    debug_bus = 8'd2;
    for (int x = 0; x < 16; x++) px(1, 1, 1, x == 5, 15'h7FFF, 9'h1FF);
    repeat (4) px(1, 1, 1, 0, 15'h0, 9'h1FF);
    nz = 0; pos = -1;
    for (int x = 0; x < 16; x++) begin
      px(1, 1, 1, x == 5, 15'h0, 9'h1FF);
      if ({a_red, a_green, a_blue} != 15'd0) begin nz++; pos = x; end
    end
    check("one_pix_cnt", nz, 1);
    check("one_pix_pos", pos, 5 + SELD);

    // colour expansion
    debug_bus = 8'd3;
    repeat (4) px(1, 1, 1, 1, 15'h7FFF, 9'b100_010_001);
    check("expand", {a_red, a_green, a_blue}, {5'h12, 5'h09, 5'h04});
    hold_px();
    hold_px();

    // enable off forces S16; horizontal blank forces black
    repeat (4) px(1, 1, 0, 1, 15'h1234, 9'h1FF);
    check("en_off", {a_red, a_green, a_blue}, 15'h1234);
    repeat (4) px(0, 1, 1, 1, 15'h1234, 9'h1FF);
    check("hblank", {a_red, a_green, a_blue}, 15'd0);
    hold_px();

    // reset in the middle of a counting line
    debug_bus = 8'd0;
    repeat (10) px(1, 1, 1, 1, 15'h0F0F, 9'h0AA);
    #1 rst_n = 1'b0;
    pxl_cen = 1'b0;
    #1;
    check("rst_mid_a", got_a(), 64'd0);
    check("rst_mid_b", got_b(), 64'd0);
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    frame(2, 40, 5);
    check("post_rst_cnt", a_cnt, 16'd5);

    // full frame with 1000 selected, then an empty frame
    debug_bus = 8'd1;
    frame(224, 320, 1000);
    check("frame_cnt", a_cnt, 16'd1000);
    check("frame_cnt_sat4", b_cnt, 4'hF);
    debug_bus = 8'd0;
    frame(4, 320, 0);
    check("empty_cnt", a_cnt, 16'd0);
    frame(1, 320, 20);
    check("cnt20", a_cnt, 16'd20);
    check("cnt20_sat4", b_cnt, 4'hF);

    // selected pixel lands on the tick the frame end is detected
    for (int x = 0; x < 20; x++) px(1, 1, 1, x >= 10 && x < 13, 15'h0123, 9'h155);
    px(1, 0, 1, 0, 15'h0123, 9'h155);
    px(1, 1, 1, 0, 15'h0123, 9'h155);
    px(1, 1, 1, 1, 15'h0123, 9'h155);
    repeat (3) px(1, 1, 1, 0, 15'h0123, 9'h155);
    check("coincide_a", a_cnt, 16'd4);
    check("coincide_b", b_cnt, 4'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
